// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared FSM type and counter sizing for the cache request arbiter
package cache_arb_pkg;
    typedef enum logic [1:0] {IDLE, CMD, RESP} arb_state_t;
    function automatic int cnt_w(input int t);
        return $clog2(t + 1);
    endfunction
    localparam int DEF_TIMEOUT = 15;
    localparam int CNT_W = cnt_w(DEF_TIMEOUT);
endpackage

// File: rtl/cache_req_arbiter_if.sv
// cache_req_arbiter_if: requester handshake, response and cache pin bundle
interface cache_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_REQ-1:0] req_valid, req_ready, req_write, resp_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] resp_rdata, cache_write_data, cache_read_data;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic resp_hit, resp_err, cache_read, cache_write, cache_hit, cache_miss;
    modport slave (
        input req_valid, req_write, req_addr, req_wdata, cache_read_data, cache_hit, cache_miss,
        output req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
        output cache_addr, cache_write_data, cache_read, cache_write
    );
    modport master (
        output req_valid, req_write, req_addr, req_wdata, cache_read_data, cache_hit, cache_miss,
        input req_ready, resp_valid, resp_rdata, resp_hit, resp_err,
        input cache_addr, cache_write_data, cache_read, cache_write
    );
endinterface

// File: rtl/cache_req_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting just after the pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);
    logic [IW-1:0] j;
    // scan from lowest to highest priority so the requester nearest ptr+1 overwrites last
    always_comb begin
        idx = '0;
        j = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = IW'((int'(ptr) + i) % NUM_REQ);
            if (valid[j]) idx = j;
        end
        any = |valid;
        grant = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares one cache among requesters, one transaction at a time, with timeout
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic clk,
    input logic reset,
    cache_req_arbiter_if.slave bus
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = cnt_w(TIMEOUT);
    arb_state_t state, state_n;
    logic [IW-1:0] ptr, gnt, pick;
    logic [NUM_REQ-1:0] onehot;
    logic any, op, hit_q, err_q, done, tmo;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [CW-1:0] cnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid(bus.req_valid),
        .ptr(ptr),
        .grant(onehot),
        .idx(pick),
        .any(any)
    );

    // the first CMD cycle (cnt == 0) ignores hit/miss because the cache outputs are sticky
    assign done = cnt != '0 && (bus.cache_hit || bus.cache_miss);
    assign tmo = cnt == CW'(TIMEOUT - 1);

    // state register; reset drops the cache strobes asynchronously since they decode from state
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // next state and all outputs, decoded from the current state
    always_comb begin
        state_n = state;
        bus.req_ready = '0;
        bus.cache_addr = '0;
        bus.cache_write_data = '0;
        bus.cache_read = 1'b0;
        bus.cache_write = 1'b0;
        bus.resp_valid = '0;
        bus.resp_rdata = '0;
        bus.resp_hit = 1'b0;
        bus.resp_err = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = onehot;
                if (any) state_n = CMD;
            end
            CMD: begin
                bus.cache_addr = addr_q;
                bus.cache_write_data = wdata_q;
                bus.cache_read = ~op;
                bus.cache_write = op;
                if (done || tmo) state_n = RESP;
            end
            RESP: begin
                bus.resp_valid = NUM_REQ'(1) << gnt;
                bus.resp_rdata = rdata_q;
                bus.resp_hit = hit_q;
                bus.resp_err = err_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // request latch, rr pointer, wait counter and response capture
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ptr <= IW'(NUM_REQ - 1);
            gnt <= '0;
            op <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hit_q <= 1'b0;
            err_q <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    ptr <= pick;
                    gnt <= pick;
                    op <= bus.req_write[pick];
                    addr_q <= bus.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_q <= bus.req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                end
                CMD: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        hit_q <= bus.cache_hit;
                        rdata_q <= op ? '0 : bus.cache_read_data;
                        err_q <= 1'b0;
                    end else if (tmo) begin
                        hit_q <= 1'b0;
                        rdata_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                RESP: cnt <= '0;
                default: ;
            endcase
        end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed checks of arbitration, sequencing, settling, timeout and reset
module tb_cache_req_arbiter;
    logic clk = 1'b0;
    logic reset;
    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    cache_req_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    cache_req_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic clear_inputs;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.cache_read_data = '0;
        bus.cache_hit = 1'b0;
        bus.cache_miss = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b00) $display("FAIL reset_ready: got %b expected 00", bus.req_ready);
        else pass++;
        total++;
        if (bus.resp_valid !== 2'b00) $display("FAIL reset_resp_valid: got %b expected 00", bus.resp_valid);
        else pass++;
        total++;
        if ({bus.cache_read, bus.cache_write} !== 2'b00)
            $display("FAIL reset_cache_rw: got %b expected 00", {bus.cache_read, bus.cache_write});
        else pass++;
        total++;
        if ({bus.resp_hit, bus.resp_err, bus.resp_rdata, bus.cache_addr} !== 66'd0)
            $display("FAIL reset_zero_outputs: got %h expected 0", {bus.resp_hit, bus.resp_err, bus.resp_rdata, bus.cache_addr});
        else pass++;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // one request from requester r, cache answers in CMD cycle k (no answer means timeout)
    task automatic run_txn(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int k, input logic h, input logic m, input logic [31:0] rd, input string nm);
        logic exp_err;
        logic [31:0] exp_rd;
        logic [1:0] oh;
        exp_err = !(h || m);
        exp_rd = (exp_err || wr) ? 32'd0 : rd;
        oh = 2'b01 << r;
        @(posedge clk);
        #1;
        bus.req_valid = oh;
        bus.req_write[r] = wr;
        bus.req_addr[r*32 +: 32] = a;
        bus.req_wdata[r*32 +: 32] = d;
        @(negedge clk);
        total++;
        if (bus.req_ready !== oh) $display("FAIL %s_ready: got %b expected %b", nm, bus.req_ready, oh);
        else pass++;
        @(posedge clk);
        #1 bus.req_valid = '0;
        for (int c = 1; c <= k; c++) begin
            if (c == k) begin
                bus.cache_hit = h;
                bus.cache_miss = m;
                bus.cache_read_data = rd;
            end
            @(negedge clk);
            total++;
            if ({bus.cache_read, bus.cache_write} !== {~wr, wr} || bus.cache_addr !== a || bus.resp_valid !== 2'b00)
                $display("FAIL %s_cmd%0d: got rw=%b addr=%h rv=%b expected rw=%b addr=%h rv=00",
                         nm, c, {bus.cache_read, bus.cache_write}, bus.cache_addr, bus.resp_valid, {~wr, wr}, a);
            else pass++;
            if (c == 1) begin
                total++;
                if (bus.cache_write_data !== d) $display("FAIL %s_wdata: got %h expected %h", nm, bus.cache_write_data, d);
                else pass++;
            end
            @(posedge clk);
            #1;
        end
        bus.cache_hit = 1'b0;
        bus.cache_miss = 1'b0;
        @(negedge clk);
        total++;
        if (bus.resp_valid !== oh || bus.resp_hit !== h || bus.resp_err !== exp_err || bus.resp_rdata !== exp_rd)
            $display("FAIL %s_resp: got rv=%b hit=%b err=%b rdata=%h expected rv=%b hit=%b err=%b rdata=%h",
                     nm, bus.resp_valid, bus.resp_hit, bus.resp_err, bus.resp_rdata, oh, h, exp_err, exp_rd);
        else pass++;
        total++;
        if ({bus.cache_read, bus.cache_write} !== 2'b00)
            $display("FAIL %s_resp_rw: got %b expected 00", nm, {bus.cache_read, bus.cache_write});
        else pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (bus.resp_valid !== 2'b00 || bus.resp_err !== 1'b0)
            $display("FAIL %s_resp_pulse: got rv=%b err=%b expected rv=00 err=0", nm, bus.resp_valid, bus.resp_err);
        else pass++;
    endtask

    task automatic test_single_write;
        run_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, 32'h0, "write_miss");
    endtask

    task automatic test_read_hit;
        run_txn(1, 1'b0, 32'h0000_0010, 32'h0, 2, 1'b1, 1'b0, 32'hDEAD_BEEF, "read_hit");
    endtask

    task automatic test_contention;
        logic [1:0] oh;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_addr = {32'h0000_0200, 32'h0000_0100};
        @(negedge clk);
        for (int t = 0; t < 4; t++) begin
            oh = 2'b01 << (t % 2);
            total++;
            if (bus.req_ready !== oh) $display("FAIL contention_ready%0d: got %b expected %b", t, bus.req_ready, oh);
            else pass++;
            @(posedge clk);
            #1;
            @(negedge clk);
            total++;
            if (bus.cache_addr !== ((t % 2) ? 32'h0000_0200 : 32'h0000_0100) || bus.req_ready !== 2'b00)
                $display("FAIL contention_cmd%0d: got addr=%h ready=%b expected addr=%h ready=00", t, bus.cache_addr,
                         bus.req_ready, (t % 2) ? 32'h0000_0200 : 32'h0000_0100);
            else pass++;
            @(posedge clk);
            #1;
            bus.cache_hit = 1'b1;
            bus.cache_read_data = 32'hA000_0000 + t;
            @(posedge clk);
            #1 bus.cache_hit = 1'b0;
            @(negedge clk);
            total++;
            if (bus.resp_valid !== oh || bus.resp_rdata !== 32'hA000_0000 + t)
                $display("FAIL contention_resp%0d: got rv=%b rdata=%h expected rv=%b rdata=%h", t, bus.resp_valid,
                         bus.resp_rdata, oh, 32'hA000_0000 + t);
            else pass++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_settling;
        @(posedge clk);
        #1;
        bus.cache_hit = 1'b1;
        bus.cache_read_data = 32'h1234_5678;
        bus.req_valid = 2'b01;
        bus.req_write = 2'b00;
        bus.req_addr[31:0] = 32'h0000_0020;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b01) $display("FAIL settle_ready: got %b expected 01", bus.req_ready);
        else pass++;
        @(posedge clk);
        #1 bus.req_valid = '0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            total++;
            if (bus.cache_read !== 1'b1 || bus.resp_valid !== 2'b00)
                $display("FAIL settle_cmd%0d: got read=%b rv=%b expected read=1 rv=00", c, bus.cache_read, bus.resp_valid);
            else pass++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        total++;
        if (bus.resp_valid !== 2'b01 || bus.resp_hit !== 1'b1 || bus.resp_rdata !== 32'h1234_5678)
            $display("FAIL settle_resp: got rv=%b hit=%b rdata=%h expected rv=01 hit=1 rdata=12345678",
                     bus.resp_valid, bus.resp_hit, bus.resp_rdata);
        else pass++;
        bus.cache_hit = 1'b0;
    endtask

    task automatic test_timeout;
        run_txn(0, 1'b0, 32'h0000_0030, 32'h0, 15, 1'b0, 1'b0, 32'hFFFF_FFFF, "timeout");
        run_txn(1, 1'b1, 32'h0000_0034, 32'h0000_0055, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, "after_timeout");
    endtask

    task automatic test_async_reset;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b10;
        bus.req_write = 2'b10;
        bus.req_addr[63:32] = 32'h0000_0040;
        @(posedge clk);
        #1 bus.req_valid = '0;
        #1;
        total++;
        if (bus.cache_write !== 1'b1) $display("FAIL areset_pre_write: got %b expected 1", bus.cache_write);
        else pass++;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.cache_read, bus.cache_write} !== 2'b00)
            $display("FAIL areset_rw_drop: got %b expected 00", {bus.cache_read, bus.cache_write});
        else pass++;
        @(negedge clk);
        total++;
        if (bus.resp_valid !== 2'b00) $display("FAIL areset_no_resp: got %b expected 00", bus.resp_valid);
        else pass++;
        @(posedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 2'b00 || bus.req_ready !== 2'b00)
            $display("FAIL areset_held: got rv=%b ready=%b expected 00 00", bus.resp_valid, bus.req_ready);
        else pass++;
        reset = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_write = 2'b00;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b01) $display("FAIL areset_priority: got %b expected 01", bus.req_ready);
        else pass++;
        @(posedge clk);
        #1 bus.req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_hit();
        test_contention();
        test_settling();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one simple_cache_controller instance among NUM_REQ requesters (e.g. fetch and load/store). It accepts one request at a time and holds the command on the cache's addr/read/write pins until the cache reports hit or miss, then returns read data and status to the winning requester. It has a timeout so that a hung cache produces an error response instead of stalling the requesters.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, data width, matches the cache
ADDR_WIDTH, 32, address width, matches the cache
TIMEOUT, 15, maximum CMD cycles to wait for cache_hit/cache_miss before an error response

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_write  in  NUM_REQ  per-requester op: 1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
resp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester
resp_rdata  out  DATA_WIDTH  shared response data, valid with resp_valid
resp_hit  out  1  1 = cache hit, 0 = miss, valid with resp_valid
resp_err  out  1  1 = timeout, valid with resp_valid
cache_addr  out  ADDR_WIDTH  to cache addr
cache_write_data  out  DATA_WIDTH  to cache write_data
cache_read  out  1  to cache read
cache_write  out  1  to cache write
cache_read_data  in  DATA_WIDTH  from cache read_data
cache_hit  in  1  from cache hit
cache_miss  in  1  from cache miss

Behaviour:
- Reset (async, active-high): state = IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 has first priority; timeout counter = 0; latched request cleared.
- States: IDLE, CMD, RESP.
- IDLE:
  - grant = first requester with req_valid set, searching from pointer+1 with wrap-around.
  - req_ready[grant] = 1 combinationally in the same cycle; the handshake completes when valid & ready.
  - On accept: latch addr, wdata and op; store grant; pointer <= grant; go to CMD.
  - No valid requests: stay in IDLE and keep pointer.
- CMD:
  - cache_addr and cache_write_data drive the latched values.
  - cache_read = ~op and cache_write = op, held for every CMD cycle.
  - The counter increments each cycle.
  - In the first CMD cycle, cache_hit/cache_miss are ignored (settling cycle; the cache's outputs are sticky).
  - From the second cycle on, if cache_hit | cache_miss: latch resp_hit = cache_hit (hit wins if both are set), latch rdata = cache_read_data for reads or 0 for writes, err = 0, go to RESP.
  - If the counter reaches TIMEOUT with no completion: err = 1, hit = 0, rdata = 0, go to RESP.
- RESP:
  - cache_read/cache_write = 0.
  - resp_valid[grant] = 1 for exactly one cycle, with resp_rdata, resp_hit and resp_err driven from the latched values.
  - Go to IDLE and clear the counter.
  - All resp_* outputs are 0 outside RESP.
- Latency: accept at cycle 0, CMD from cycle 1, completion sampled at cycle k ≥ 2, resp_valid at k+1, next accept possible at k+2.
- Requesters must hold req_* stable while valid and not ready. Dropping valid before ready is permitted; that request is then not served.
- Requests arriving during CMD/RESP wait; req_ready stays 0 outside IDLE.
- Fairness: a requester that keeps req_valid asserted is served within NUM_REQ transactions.
- Reset mid-transaction: everything returns to reset values immediately, no response is issued, and cache_read/cache_write drop asynchronously.
- Counter width: $clog2(TIMEOUT+1).

Decomposition:
- Package cache_arb_pkg holds:
  - arb_state_t enum {IDLE, CMD, RESP}
  - localparam CNT_W
- Sub-module rr_arbiter (NUM_REQ): combinational rotate/priority pick from req_valid and pointer, producing a one-hot grant, grant index and any_valid. The pointer register lives in the parent.

Test Plan:
- Reset then single write: req 0 writes addr 0x0000_0010, data 0xDEAD_BEEF; the cache raises miss in CMD cycle 3 -> resp_valid[0] one pulse, resp_hit = 0, resp_err = 0, resp_rdata = 0; cache_write is high for exactly CMD cycles 1..3.
- Read hit after write: req 1 reads 0x0000_0010; cache_hit with read_data 0xDEAD_BEEF -> resp_valid[1], resp_hit = 1, resp_rdata = 0xDEAD_BEEF.
- Contention: req 0 and req 1 valid continuously for 4 transactions -> grants alternate 0, 1, 0, 1; req_ready is never asserted for both in one cycle.
- Settling cycle: cache_hit held high from before the request -> completion is not taken in CMD cycle 1, only in cycle 2.
- Timeout: cache never responds -> resp_err = 1 exactly TIMEOUT(15) CMD cycles after CMD entry, resp_hit = 0, then back to IDLE and a new request is accepted.
- Async reset during CMD: assert reset mid-cycle -> cache_read/cache_write go to 0 before the next clock edge, no resp_valid, and after release requester 0 wins over a simultaneous requester 1.
